// File: rtl/boot_loader.sv
// Boot loader: zeroes the instruction memory, streams a program into it,
// then releases the core for a fixed budget of clock-enabled cycles.
module boot_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] run_cycles,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  input  logic          s_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          core_reset,
  output logic          core_run,
  output logic [AW:0]   words_loaded,
  output logic [CW-1:0] cycle_count,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   LAST_WORD = (AW + 1)'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic [CW-1:0] run_target;
  logic          err_q;

  // Sequencer: state, clear pointer, latched budget and the status counters.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking = would let later statements observe half-updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      clr_addr     <= '0;
      run_target   <= '0;
      words_loaded <= '0;
      cycle_count  <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= CLEAR;
            clr_addr     <= '0;
            run_target   <= run_cycles;
            words_loaded <= '0;
            cycle_count  <= '0;
            err_q        <= 1'b0;
          end
        end
        CLEAR: begin
          // DEPTH is a power of two, so the pointer wraps back to 0 on exit.
          clr_addr <= clr_addr + AW'(1);
          if (clr_addr == LAST_ADDR) state <= LOAD;
        end
        LOAD: begin
          if (s_valid) begin
            words_loaded <= words_loaded + (AW + 1)'(1);
            if (s_last) begin
              state <= RUN;
            end else if (words_loaded == LAST_WORD) begin
              // Memory is full but the stream has not ended: refuse to run.
              err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (run_target == '0) begin
            state <= DONE;
          end else begin
            cycle_count <= cycle_count + CW'(1);
            if (cycle_count == run_target - CW'(1)) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the state register; memory writes in LOAD follow s_valid
  // in the same cycle so a word is stored on the beat it is accepted.
  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    s_ready    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_reset = 1'b0;
    core_run   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = err_q;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_addr;
      end
      LOAD: begin
        busy     = 1'b1;
        s_ready  = 1'b1;
        mem_we   = s_valid;
        mem_addr = words_loaded[AW-1:0];
        if (s_valid) mem_wdata = s_data;
      end
      RUN: begin
        busy       = 1'b1;
        core_reset = 1'b1;
        core_run   = (run_target != '0);
      end
      DONE: begin
        core_reset = 1'b1;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter DEPTH, 1024, instruction-memory depth in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter AW, $clog2(DEPTH), word-address width.
REQ-003 SHALL have parameter CW, 16, run-cycle counter width.
REQ-004 SHALL have port clk input 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port reset input 1, asynchronous active-low reset.
REQ-006 SHALL have port start input 1, begin load/run sequence (sampled in IDLE and DONE only).
REQ-007 SHALL have port run_cycles input CW, core execution budget in cycles, sampled when start is accepted.
REQ-008 SHALL have port s_valid input 1, program word valid.
REQ-009 SHALL have port s_ready output 1, loader accepts program word.
REQ-010 SHALL have port s_data input 32, program word.
REQ-011 SHALL have port s_last input 1, marks final program word.
REQ-012 SHALL have port mem_we output 1, instruction-memory write enable.
REQ-013 SHALL have port mem_addr output AW, instruction-memory word address.
REQ-014 SHALL have port mem_wdata output 32, instruction-memory write data.
REQ-015 SHALL have port core_reset output 1, active-low reset to core.
REQ-016 SHALL have port core_run output 1, core clock-enable.
REQ-017 SHALL have port words_loaded output AW+1, count of program words accepted.
REQ-018 SHALL have port cycle_count output CW, cycles the core has run.
REQ-019 SHALL have ports busy, done, error output 1 each, status flags.

Function
REQ-020 SHALL implement states IDLE, CLEAR, LOAD, RUN, DONE; busy=1 in CLEAR/LOAD/RUN only.
REQ-021 IDLE/DONE: start=1 -> CLEAR next cycle; latch run_cycles; clear words_loaded, cycle_count, done, error.
REQ-022 CLEAR: mem_we=1, mem_wdata=0, mem_addr=0..DEPTH-1 one per cycle; exactly DEPTH cycles, then LOAD.
REQ-023 LOAD: s_ready=1 (0 in all other states); on s_valid&s_ready write s_data to mem_addr=words_loaded same cycle (mem_we=1), words_loaded+1.
REQ-024 LOAD: mem_we=0 in cycles without a transfer; s_data ignored when s_valid=0.
REQ-025 Transfer with s_last=1 -> RUN next cycle (that word written).
REQ-026 Transfer at address DEPTH-1 with s_last=0 -> word written, error=1, DONE next cycle; RUN skipped.
REQ-027 core_reset=0 in IDLE, CLEAR, LOAD; core_reset=1 in RUN and DONE (core state retained for inspection).
REQ-028 RUN: core_run=1 for exactly latched run_cycles cycles, cycle_count incrementing each such cycle; then DONE.
REQ-029 Latched run_cycles=0: RUN lasts one cycle with core_run=0, cycle_count stays 0, then DONE.
REQ-030 DONE: done=1, core_run=0, mem_we=0; holds until start or reset.
REQ-031 start asserted in CLEAR/LOAD/RUN SHALL be ignored.
REQ-032 cycle_count SHALL saturate-free; run length bounded by CW-bit run_cycles, no wrap possible.

Reset
REQ-033 reset=0 SHALL asynchronously force IDLE: s_ready, mem_we, core_run, busy, done, error =0; core_reset=0; mem_addr, mem_wdata, words_loaded, cycle_count =0.
REQ-034 Reset asserted mid-CLEAR/LOAD/RUN SHALL abort without further memory writes; release returns to IDLE awaiting start.

Verification
REQ-035 DEPTH=8, start, 3 words (ADDI x1,x1,42 / ADDI x2,x2,21 / OR x3,x1,x2, last on third), run_cycles=5 -> 8 zero writes, 3 writes at addr 0..2, words_loaded=3, core_run high 5 cycles, done=1, cycle_count=5, error=0.
REQ-036 LOAD with s_valid toggling every other cycle -> writes only on valid cycles, addresses contiguous, no lost/duplicated word.
REQ-037 DEPTH=8, 8 words none with s_last -> 8th written at addr 7, error=1, done=1, core_run never asserted.
REQ-038 run_cycles=0 -> RUN one cycle, core_run never 1, cycle_count=0, done=1.
REQ-039 reset pulsed low during RUN at cycle 2 -> all outputs at reset values immediately; subsequent start repeats full sequence.
REQ-040 start from DONE -> done/error cleared, CLEAR re-zeroes memory, new program loaded and run.
